// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the video memory arbiter, its two requesters and the memory.
// Signal names are seen from the arbiter: i_* are driven into it, o_* are driven by it.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_dreq;
    logic              o_dack;
    logic              o_dvalid;
    logic [DATA_W-1:0] o_ddata;

    logic              i_creq;
    logic              i_cwe;
    logic [ADDR_W-1:0] i_caddr;
    logic [DATA_W-1:0] i_cwdata;
    logic              o_cack;
    logic              o_cvalid;
    logic [DATA_W-1:0] o_crdata;

    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_dreq, i_creq, i_cwe, i_caddr, i_cwdata, i_mem_rdata,
        output o_dack, o_dvalid, o_ddata, o_cack, o_cvalid, o_crdata,
               o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_dreq, i_creq, i_cwe, i_caddr, i_cwdata, i_mem_rdata,
        input  o_dack, o_dvalid, o_ddata, o_cack, o_cvalid, o_crdata,
               o_mem_addr, o_mem_we, o_mem_wdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Arbitrates one single-port video memory between display fetch and CPU, generates the
// display read address and routes read data back through a latency-matched tag pipeline.
module vga_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2,
    parameter int STARVE  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_intv,
    input  logic [ADDR_W-1:0] i_base,
    vga_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_e;

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
        $error("vga_mem_arbiter: MEM_LAT out of range 1..7");
    end
    if (STARVE < 1 || STARVE > 255) begin : g_bad_starve
        $error("vga_mem_arbiter: STARVE out of range 1..255");
    end

    logic [7:0]        r_starve;
    logic [ADDR_W-1:0] r_dcnt;
    logic              r_reset_q;
    tag_e              r_tag [MEM_LAT];

    logic              w_block;
    logic              w_force;
    logic              w_cgnt;
    logic              w_dgnt;
    tag_e              w_tag_in;
    logic [DATA_W-1:0] w_rdata;

    // Grants stay off through the reset cycle and the one after it.
    assign w_block = i_reset | r_reset_q;
    assign w_force = (r_starve >= 8'(STARVE));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_cgnt   = 1'b0;
        w_dgnt   = 1'b0;
        w_tag_in = TAG_NONE;
        if (!w_block) begin
            if (bus.i_creq && (!bus.i_dreq || w_force)) begin
                w_cgnt   = 1'b1;
                w_tag_in = bus.i_cwe ? TAG_NONE : TAG_CPU;
            end else if (bus.i_dreq) begin
                w_dgnt   = 1'b1;
                w_tag_in = TAG_DISP;
            end
        end
    end

    assign bus.o_dack      = w_dgnt;
    assign bus.o_cack      = w_cgnt;
    assign bus.o_mem_addr  = w_cgnt ? bus.i_caddr : r_dcnt;
    assign bus.o_mem_we    = w_cgnt & bus.i_cwe;
    assign bus.o_mem_wdata = bus.i_cwdata;

    // Read data is steered, not registered: the tag at the last stage marks the owner.
    assign w_rdata      = bus.i_mem_rdata;
    assign bus.o_ddata  = w_rdata;
    assign bus.o_crdata = w_rdata;
    assign bus.o_dvalid = !i_reset && (r_tag[MEM_LAT-1] == TAG_DISP);
    assign bus.o_cvalid = !i_reset && (r_tag[MEM_LAT-1] == TAG_CPU);

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge i_clk) begin
        r_reset_q <= i_reset;
        if (i_reset) begin
            r_starve <= '0;
            r_dcnt   <= '0;
            // NOTE: the tag array is reset because it qualifies the valids; data is never stored.
            for (int i = 0; i < MEM_LAT; i++) begin
                r_tag[i] <= TAG_NONE;
            end
        end else begin
            if (bus.i_creq && !w_cgnt) begin
                r_starve <= (r_starve == 8'hFF) ? r_starve : r_starve + 8'd1;
            end else begin
                r_starve <= '0;
            end

            if (i_intv) begin
                r_dcnt <= i_base;
            end else if (w_dgnt) begin
                r_dcnt <= r_dcnt + ADDR_W'(1);
            end

            r_tag[0] <= w_tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: directed scenarios then randomized traffic,
// compared cycle by cycle against a rule-level reference model with a shadow memory.
module tb_vga_mem_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 2;
    localparam int STARVE  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              intv;
    logic [ADDR_W-1:0] base;

    vga_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE(STARVE)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_intv  (intv),
        .i_base  (base),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory device: writes in the grant cycle, read data appears MEM_LAT cycles later.
    logic [DATA_W-1:0] mem [65536];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        rd_pipe[0] <= mem[bus.o_mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.i_mem_rdata = rd_pipe[MEM_LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          is_cpu;
        logic [15:0] data;
    } ret_t;

    ret_t        ret_q [$];
    logic [15:0] ref_wr [int];
    int          m_starve = 0;
    int          m_dcnt   = 0;
    bit          m_rst_prev = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 40503 + 4660) & 16'hFFFF);
    endfunction

    function automatic logic [15:0] ref_read(input int a);
        return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, compare mid-cycle, then advance the model.
    task automatic step(input bit rst, input bit dq, input bit cq, input bit cw,
                        input logic [15:0] ca, input logic [15:0] cd,
                        input bit iv, input logic [15:0] bs,
                        output bit eg_c, output bit eg_d, output bit obs_c);
        bit          blocked;
        bit          exp_dv;
        bit          exp_cv;
        logic [15:0] exp_rd;
        ret_t        r;

        reset = rst; intv = iv; base = bs;
        bus.i_dreq = dq; bus.i_creq = cq; bus.i_cwe = cw;
        bus.i_caddr = ca; bus.i_cwdata = cd;

        blocked = rst || m_rst_prev;
        eg_c = !blocked && cq && (!dq || m_starve >= STARVE);
        eg_d = !blocked && dq && !eg_c;

        exp_dv = 1'b0; exp_cv = 1'b0; exp_rd = '0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (!rst) begin
                exp_dv = !r.is_cpu;
                exp_cv = r.is_cpu;
                exp_rd = r.data;
            end
        end

        @(negedge clk);
        obs_c = bus.o_cack;
        check("dack", 32'(bus.o_dack), 32'(eg_d));
        check("cack", 32'(bus.o_cack), 32'(eg_c));
        check("mem_we", 32'(bus.o_mem_we), 32'(eg_c && cw));
        if (eg_d) check("disp_addr", 32'(bus.o_mem_addr), 32'(m_dcnt));
        if (eg_c) check("cpu_addr", 32'(bus.o_mem_addr), 32'(ca));
        if (eg_c && cw) check("cpu_wdata", 32'(bus.o_mem_wdata), 32'(cd));
        check("dvalid", 32'(bus.o_dvalid), 32'(exp_dv));
        check("cvalid", 32'(bus.o_cvalid), 32'(exp_cv));
        if (exp_dv) check("ddata", 32'(bus.o_ddata), 32'(exp_rd));
        if (exp_cv) check("crdata", 32'(bus.o_crdata), 32'(exp_rd));

        @(posedge clk);
        #1;
        if (rst) begin
            m_starve = 0;
            m_dcnt   = 0;
            ret_q.delete();
        end else begin
            if (eg_d) begin
                r.due = cyc + MEM_LAT; r.is_cpu = 1'b0; r.data = ref_read(m_dcnt);
                ret_q.push_back(r);
            end
            if (eg_c && !cw) begin
                r.due = cyc + MEM_LAT; r.is_cpu = 1'b1; r.data = ref_read(int'(ca));
                ret_q.push_back(r);
            end
            if (eg_c && cw) ref_wr[int'(ca)] = cd;
            m_starve = (cq && !eg_c) ? ((m_starve < 255) ? m_starve + 1 : 255) : 0;
            m_dcnt   = iv ? int'(bs) : (m_dcnt + (eg_d ? 1 : 0)) % 65536;
        end
        m_rst_prev = rst;
        cyc++;
    endtask

    initial begin
        bit          gc, gd, oc;
        int          first_cack;
        bit          pd, pc, pw, rr, iv;
        logic [15:0] pa, pdat, bs;

        for (int a = 0; a < 65536; a++) mem[a] = init_val(a);
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;

        // Reset with a display request pending: no grant during reset or the cycle after
        step(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(1, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Frame start at 0x0100, then four back-to-back display reads
        step(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h0100, gc, gd, oc);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // CPU write then read-back of the same word
        step(0, 0, 1, 1, 16'h1234, 16'hBEEF, 0, 16'h0, gc, gd, oc);
        step(0, 0, 1, 0, 16'h1234, 16'h0, 0, 16'h0, gc, gd, oc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Both requesting continuously: CPU forced through after STARVE display grants
        first_cack = -1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 0, 16'h1234, 16'h0, 0, 16'h0, gc, gd, oc);
            if (oc && first_cack < 0) first_cack = i;
        end
        check("starve_first_cack", 32'(first_cack), 32'(STARVE));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Frame start coinciding with a grant: grant uses old counter
        step(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h0050, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 1, 16'h2000, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Counter wrap from 0xFFFF
        step(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'hFFFF, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Reset one cycle after a display grant drops the in-flight read
        step(0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h0777, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        step(0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        // Randomized traffic; requests are held until acknowledged
        pd = 1'b0; pc = 1'b0; pw = 1'b0; pa = '0; pdat = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pd) pd = ($urandom_range(0, 3) != 0);
            if (!pc) begin
                pc   = ($urandom_range(0, 2) == 0);
                pw   = 1'($urandom_range(0, 1));
                pa   = 16'h4000 + 16'($urandom_range(0, 15));
                pdat = 16'($urandom);
            end
            rr = ($urandom_range(0, 149) == 0);
            iv = ($urandom_range(0, 31) == 0);
            bs = 16'($urandom);
            step(rr, pd, pc, pw, pa, pdat, iv, bs, gc, gd, oc);
            if (gd) pd = 1'b0;
            if (gc) pc = 1'b0;
        end
        for (int i = 0; i < MEM_LAT + 2; i++) step(0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0, gc, gd, oc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
Shares one single-port video memory between the display fetch path and a CPU port. It generates the display read address. The counter reloads from a frame base address at each frame start, taken from the timing generator's o_intv. It then advances by one for each granted display read. Display reads have priority; a starvation guard ensures CPU accesses still get through.

Parameters:
ADDR_W, 16, memory word address width
DATA_W, 16, memory data width
MEM_LAT, 2, memory read latency in cycles, from address issue to i_mem_rdata valid; range 1..7
STARVE, 8, number of consecutive cycles a pending CPU request may lose before it is forced through; range 1..255

Ports:
i_clk  in  1  system clock (pixel clock domain)
i_reset  in  1  synchronous, active-high reset
i_intv  in  1  frame-start pulse from the timing generator (o_intv)
i_base  in  ADDR_W  frame base address; sampled when i_intv=1
i_dreq  in  1  display fetch request; level, held until o_dack
o_dack  out  1  display request granted this cycle
o_dvalid  out  1  display read data valid
o_ddata  out  DATA_W  display read data
i_creq  in  1  CPU request; level, held until o_cack
i_cwe  in  1  CPU write enable (1=write, 0=read); stable while i_creq=1
i_caddr  in  ADDR_W  CPU address
i_cwdata  in  DATA_W  CPU write data
o_cack  out  1  CPU request granted this cycle
o_cvalid  out  1  CPU read data valid
o_crdata  out  DATA_W  CPU read data
o_mem_addr  out  ADDR_W  memory address
o_mem_we  out  1  memory write strobe
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Grant logic is combinational from the current inputs and state. At most one grant per cycle. The memory is driven combinationally in the grant cycle.
- Display grant: o_dack=1, o_mem_addr=display counter, o_mem_we=0.
- CPU grant: o_cack=1, o_mem_addr=i_caddr, o_mem_we=i_cwe, o_mem_wdata=i_cwdata.
- No grant: o_mem_we=0. o_mem_addr and o_mem_wdata are don't-care.
- Priority: i_dreq wins over i_creq unless the starvation counter has reached STARVE; then the CPU wins for that cycle.
- Starvation counter (8 bit):
  - Increments in each cycle where i_creq=1 and the CPU is not granted (saturates at 255).
  - Clears on a CPU grant or when i_creq=0.
- Display address counter:
  - On i_intv=1, next value is i_base. i_intv has priority over an increment in the same cycle.
  - Otherwise it increments by 1 on each display grant, wrapping modulo 2^ADDR_W.
  - A grant in the i_intv cycle uses the old counter value.
- Read return pipeline:
  - MEM_LAT-deep shift register of tags {none, display, cpu}.
  - The tag is inserted in the grant cycle. CPU writes insert "none".
  - At depth MEM_LAT, tag display gives o_dvalid=1 with o_ddata=i_mem_rdata. Tag cpu gives o_cvalid=1 with o_crdata=i_mem_rdata.
  - Data is passed through combinationally when valid. o_ddata and o_crdata are don't-care otherwise.
  - Read latency is MEM_LAT cycles from the ack cycle. Full throughput: one access per cycle, back-to-back reads allowed.
- Reset:
  - Clears the tag pipeline, the starvation counter and the display counter (to 0).
  - All acks and valids are 0 during the reset cycle and the cycle after. No grants are issued while i_reset=1.
  - Reset mid-operation drops in-flight reads: no valid is asserted for them.
- Requesters must deassert a request or present a new one in the cycle after an ack. A held request is re-granted as a new access.

Test Plan:
- Reset, then i_dreq=1 for 4 cycles, MEM_LAT=2, i_base=0x0100 with i_intv pulsed once beforehand -> o_dack on 4 consecutive cycles; o_mem_addr=0x0100..0x0103; o_dvalid 2 cycles after each ack with the memory model's data.
- Only i_creq=1 with i_cwe=1, i_caddr=0x1234, i_cwdata=0xBEEF -> o_cack same cycle; o_mem_we=1, addr 0x1234, wdata 0xBEEF; o_cvalid never asserted.
- i_dreq and i_creq held continuously (CPU read), STARVE=8 -> 8 display grants, then 1 CPU grant on the 9th cycle, then display resumes; o_cvalid 2 cycles after o_cack.
- i_intv in the same cycle as a display grant with counter=0x0050, i_base=0x2000 -> that grant uses 0x0050; next display grant uses 0x2000.
- Counter at 0xFFFF with a display grant -> next address 0x0000.
- Reset asserted 1 cycle after a display read grant -> no o_dvalid for that read; all outputs 0 and counter 0 after reset.
